// File: rtl/math_pkg.sv
// Shared definitions for the math_op_scheduler slice: op codes, FSM states,
// datapath width and the two's-complement overflow rule.
package math_pkg;

    localparam int MATH_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Overflow from sign bits only: an add overflows when like-signed operands
    // produce a result of the other sign; a subtract when unlike-signed ones do.
    function automatic logic ovf_calc(
        input logic op,
        input logic a_msb,
        input logic b_msb,
        input logic r_msb
    );
        logic same_sign;
        same_sign = (a_msb == b_msb);
        if (op == OP_ADD) begin
            ovf_calc = same_sign && (r_msb != a_msb);
        end else begin
            ovf_calc = !same_sign && (r_msb != a_msb);
        end
    endfunction

endpackage

// File: rtl/math_block.sv
// Shared arithmetic datapath: produces both A+B and A-B, modulo 2^WIDTH.
module math_block
    import math_pkg::*;
#(
    parameter int WIDTH = MATH_W
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] AplusB,
    output logic [WIDTH-1:0] AminusB
);

    assign AplusB  = A + B;
    assign AminusB = A - B;

endmodule

// File: rtl/math_op_scheduler.sv
// Two-requester scheduler for the shared math_block: arbitrates, latches the
// winner's operation, runs it through the datapath and returns flagged results.
module math_op_scheduler
    import math_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic             op0,
    input  logic             op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             busy
);

    if (WIDTH != MATH_W) begin : g_width_check
        $error("math_op_scheduler: WIDTH must equal math_block width");
    end

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             win_q, win_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;

    logic             pick;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] r_sel;

    math_block #(
        .WIDTH(WIDTH)
    ) u_math_block (
        .A      (a_q),
        .B      (b_q),
        .AplusB (sum),
        .AminusB(diff)
    );

    // Winner when at least one request is pending; unused when req is zero.
    always_comb begin
        pick = 1'b0;
        if (FIXED_PRIO) begin
            pick = !req[0];
        end else if (req == 2'b11) begin
            pick = ptr_q;
        end else begin
            pick = req[1];
        end
    end

    assign r_sel = (op_q == OP_SUB) ? diff : sum;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        gnt_d    = 2'b00;
        done_d   = 2'b00;
        result_d = result_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    win_d   = pick;
                    op_d    = pick ? op1 : op0;
                    a_d     = pick ? a1 : a0;
                    b_d     = pick ? b1 : b0;
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                result_d = r_sel;
                zero_d   = (r_sel == '0);
                neg_d    = r_sel[WIDTH-1];
                ovf_d    = ovf_calc(op_q, a_q[WIDTH-1], b_q[WIDTH-1], r_sel[WIDTH-1]);
                done_d   = win_q ? 2'b10 : 2'b01;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (!FIXED_PRIO) begin
                    ptr_d = ~win_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Async reset also aborts any in-flight operation: no done is produced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ptr_q    <= 1'b0;
            win_q    <= 1'b0;
            op_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign result = result_q;
    assign zero   = zero_q;
    assign neg    = neg_q;
    assign ovf    = ovf_q;
    assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_math_op_scheduler.sv
// Directed bench for math_op_scheduler with a scoreboard of expected completions.
module tb_math_op_scheduler;

    typedef struct {
        logic [1:0] done;
        logic [3:0] result;
        logic       zero;
        logic       neg;
        logic       ovf;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic       op0, op1;
    logic [3:0] a0, b0, a1, b1;
    logic [1:0] gnt, done;
    logic [3:0] result;
    logic       zero, neg, ovf, busy;

    logic [1:0] fp_gnt, fp_done;
    logic [3:0] fp_result;
    logic       fp_zero, fp_neg, fp_ovf, fp_busy;

    int         total;
    int         bad;
    exp_t       sbq[$];
    exp_t       e_mon;
    logic [1:0] fp_order[$];
    logic       fp_rec;

    math_op_scheduler #(.WIDTH(4), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt(gnt), .done(done), .result(result), .zero(zero),
        .neg(neg), .ovf(ovf), .busy(busy)
    );

    math_op_scheduler #(.WIDTH(4), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req(req), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt(fp_gnt), .done(fp_done), .result(fp_result), .zero(fp_zero),
        .neg(fp_neg), .ovf(fp_ovf), .busy(fp_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    function automatic exp_t model(input int idx, input logic op, input logic [3:0] a,
                                   input logic [3:0] b);
        exp_t e;
        int   sa, sb, s;
        sa       = int'($signed(a));
        sb       = int'($signed(b));
        s        = op ? (sa - sb) : (sa + sb);
        e.done   = (idx == 0) ? 2'b01 : 2'b10;
        e.result = s[3:0];
        e.zero   = (s[3:0] == 4'd0);
        e.neg    = s[3];
        e.ovf    = (s > 7) || (s < -8);
        return e;
    endfunction

    // One single-requester operation; operands are scrambled after gnt to
    // show that only the latched copy is used.
    task automatic issue(input int idx, input logic op, input logic [3:0] a,
                         input logic [3:0] b);
        logic [1:0] oh;
        oh = (idx == 0) ? 2'b01 : 2'b10;
        @(posedge clk); #1;
        if (idx == 0) begin
            op0 = op; a0 = a; b0 = b;
        end else begin
            op1 = op; a1 = a; b1 = b;
        end
        req = oh;
        sbq.push_back(model(idx, op, a, b));
        @(posedge clk); #1;
        chk("gnt_latency", 32'(gnt), 32'(oh));
        chk("busy_exec", 32'(busy), 32'd1);
        req = 2'b00;
        a0 = ~a0; b0 = ~b0; a1 = ~a1; b1 = ~b1; op0 = ~op0; op1 = ~op1;
        @(posedge clk); #1;
        chk("done_latency", 32'(done), 32'(oh));
    endtask

    // Scoreboard side: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done != 2'b00) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e_mon = sbq.pop_front();
                    chk("sb_done", 32'(done), 32'(e_mon.done));
                    chk("sb_result", 32'(result), 32'(e_mon.result));
                    chk("sb_zero", 32'(zero), 32'(e_mon.zero));
                    chk("sb_neg", 32'(neg), 32'(e_mon.neg));
                    chk("sb_ovf", 32'(ovf), 32'(e_mon.ovf));
                end
            end
            if (gnt != 2'b00) begin
                chk("gnt_done_excl", 32'(done), 32'd0);
            end
            if (fp_rec && fp_done != 2'b00) begin
                fp_order.push_back(fp_done);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        total  = 0;
        bad    = 0;
        fp_rec = 1'b0;
        rst_n  = 1'b0;
        req    = 2'b00;
        op0 = 1'b0; op1 = 1'b0;
        a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_neg", 32'(neg), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("idle_busy", 32'(busy), 32'd0);
        end

        issue(0, 1'b0, 4'd3, 4'd4);
        issue(1, 1'b1, 4'd3, 4'd5);
        issue(0, 1'b0, 4'd7, 4'd9);
        issue(0, 1'b0, 4'd7, 4'd1);
        issue(1, 1'b1, 4'd8, 4'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("result_hold", 32'(result), 32'd7);
        chk("ovf_hold", 32'(ovf), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);

        // Abort an operation while it is in EXEC.
        @(posedge clk); #1;
        a0 = 4'd2; b0 = 4'd2; op0 = 1'b0; req = 2'b01;
        @(posedge clk); #1;
        chk("abort_gnt", 32'(gnt), 32'b01);
        rst_n = 1'b0;
        req   = 2'b00;
        #1;
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_gnt_clr", 32'(gnt), 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_no_done", 32'(sbq.size()), 32'd0);
        issue(0, 1'b0, 4'd2, 4'd2);

        // Contention from a freshly reset pointer.
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        a0 = 4'd1; b0 = 4'd1; op0 = 1'b0;
        a1 = 4'd5; b1 = 4'd2; op1 = 1'b1;
        req    = 2'b11;
        fp_rec = 1'b1;
        sbq.push_back(model(0, 1'b0, 4'd1, 4'd1));
        sbq.push_back(model(1, 1'b1, 4'd5, 4'd2));
        sbq.push_back(model(0, 1'b0, 4'd1, 4'd1));
        repeat (9) @(posedge clk);
        #1;
        req = 2'b00;
        repeat (4) @(posedge clk);
        #1;
        fp_rec = 1'b0;
        chk("rr_drain", 32'(sbq.size()), 32'd0);
        chk("fp_count", 32'(fp_order.size()), 32'd3);
        for (int i = 0; i < fp_order.size(); i++) begin
            chk("fp_order", 32'(fp_order[i]), 32'b01);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
